// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
package mem_access_ctrl_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // Opcodes the control decoder maps onto memRead / memWrite.
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_t;

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Load/store to valid/ack data-memory bus bridge that stalls the core until completion.
// Optional misaligned-access trap is compiled in with `define MISALIGN_TRAP_EN.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              fault
);

    state_t state;

    // Stall must rise in the very cycle a command appears, so it is decoded
    // from the current state and the live command rather than registered.
    always_comb begin
        stall = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE:    stall = mem_read | mem_write;
                REQ:     stall = 1'b1;
                FAULT:   stall = 1'b1;
                default: stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            fault       <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            fault       <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        bus_addr  <= addr;
                        bus_wdata <= wdata;
                        bus_we    <= mem_write;
`ifdef MISALIGN_TRAP_EN
                        if (is_misaligned(addr[1:0])) begin
                            state <= FAULT;
                        end else begin
                            state   <= REQ;
                            bus_req <= 1'b1;
                        end
`else
                        state   <= REQ;
                        bus_req <= 1'b1;
`endif
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        state   <= DONE;
                        if (!bus_we) begin
                            rdata       <= bus_rdata;
                            rdata_valid <= 1'b1;
                        end
                    end
                end
                // The command is still held during DONE; returning to IDLE
                // without looking at it prevents a duplicate access.
                DONE: begin
                    state <= IDLE;
                end
`ifdef MISALIGN_TRAP_EN
                FAULT: begin
                    state <= DONE;
                    fault <= 1'b1;
                end
`endif
                default: begin
                    state   <= IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: random loads/stores against a memory reference model.
module tb_mem_access_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } bus_txn_t;

    typedef struct packed {
        logic          is_fault;
        logic [DW-1:0] d;
    } resp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_read, mem_write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          stall;
    logic [DW-1:0] rdata;
    logic          rdata_valid;
    logic          bus_req, bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_ack;
    logic [DW-1:0] bus_rdata;
    logic          fault;

    logic resp_ack;
    logic force_ack;
    assign bus_ack = resp_ack | force_ack;

    int checks   = 0;
    int failures = 0;

    bus_txn_t bus_q[$];
    resp_t    resp_q[$];
    int       ack_q[$];

    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] bus_mem [logic [AW-1:0]];
    logic [DW-1:0] last_rd;

    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata),
        .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .fault(fault)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] initVal(input logic [AW-1:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    function automatic logic [DW-1:0] refRead(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : initVal(a);
    endfunction

    task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Issue one command (or an idle cycle) and follow it through to its DONE cycle.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input int wt);
        logic          trap;
        int            exp_stall;
        int            got;
        logic [DW-1:0] exp_rd;
        trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
        trap = (a[1:0] != 2'b00);
`endif
        @(negedge clk);
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = d;
        if (!(rd || wr)) begin
            #1;
            checkOutput("idle_stall", 64'(stall), 64'd0);
            checkOutput("idle_rdata_hold", 64'(rdata), 64'(last_rd));
            return;
        end
        if (trap) begin
            resp_q.push_back('{1'b1, '0});
            exp_stall = 2;
        end else begin
            bus_q.push_back('{wr, a, d});
            ack_q.push_back(wt);
            exp_stall = 2 + wt;
            if (wr) begin
                ref_mem[a] = d;
            end else begin
                exp_rd = refRead(a);
                resp_q.push_back('{1'b0, exp_rd});
                last_rd = exp_rd;
            end
        end
        got = 0;
        #1;
        while (stall && got < 64) begin
            got++;
            @(negedge clk);
            #1;
        end
        checkOutput("stall_cycles", 64'(got), 64'(exp_stall));
        checkOutput("done_rdata_valid", 64'(rdata_valid), 64'(!wr && !trap));
        checkOutput("done_fault", 64'(fault), 64'(trap));
        checkOutput("done_rdata", 64'(rdata), 64'(last_rd));
    endtask

    task automatic resetMidReq();
        @(negedge clk);
        mem_read  = 1'b1;
        mem_write = 1'b0;
        addr      = 32'h300;
        wdata     = 32'h55AA55AA;
        bus_q.push_back('{1'b0, 32'h300, 32'h55AA55AA});
        ack_q.push_back(6);
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst_pre_req", 64'(bus_req), 64'd1);
        checkOutput("rst_pre_stall", 64'(stall), 64'd1);
        #1;
        rst_n    = 1'b0;
        mem_read = 1'b0;
        #1;
        checkOutput("rst_req_drop", 64'(bus_req), 64'd0);
        checkOutput("rst_stall_drop", 64'(stall), 64'd0);
        checkOutput("rst_bus_addr", 64'(bus_addr), 64'd0);
        last_rd = '0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            force_ack = 1'b1;
            #1;
            checkOutput("late_ack_req", 64'(bus_req), 64'd0);
            checkOutput("late_ack_stall", 64'(stall), 64'd0);
        end
        @(negedge clk);
        force_ack = 1'b0;
        #1;
        checkOutput("late_ack_rdata", 64'(rdata), 64'd0);
    endtask

    // Memory device: acks after a per-transaction wait taken from ack_q.
    initial begin
        int busy;
        int cnt;
        resp_ack  = 1'b0;
        bus_rdata = '0;
        busy      = 0;
        cnt       = 0;
        forever begin
            @(negedge clk);
            resp_ack  = 1'b0;
            bus_rdata = $urandom;
            if (!rst_n) begin
                busy = 0;
            end else if (bus_req) begin
                if (busy == 0) begin
                    busy = 1;
                    cnt  = (ack_q.size() > 0) ? ack_q.pop_front() : 0;
                end
                if (cnt == 0) begin
                    resp_ack = 1'b1;
                    busy     = 0;
                    if (bus_we) bus_mem[bus_addr] = bus_wdata;
                    else bus_rdata = bus_mem.exists(bus_addr) ? bus_mem[bus_addr] : initVal(bus_addr);
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a request or response.
    initial begin
        bus_txn_t cur;
        bus_txn_t et;
        resp_t    r;
        logic     prev_req;
        prev_req = 1'b0;
        cur      = '0;
        forever begin
            @(negedge clk);
            if (bus_req && !prev_req) begin
                if (bus_q.size() == 0) begin
                    checkOutput("unexpected_bus_req", 64'd1, 64'd0);
                end else begin
                    et = bus_q.pop_front();
                    checkOutput("bus_we", 64'(bus_we), 64'(et.we));
                    checkOutput("bus_addr", 64'(bus_addr), 64'(et.a));
                    checkOutput("bus_wdata", 64'(bus_wdata), 64'(et.d));
                end
                cur = '{bus_we, bus_addr, bus_wdata};
            end else if (bus_req) begin
                checkOutput("bus_we_hold", 64'(bus_we), 64'(cur.we));
                checkOutput("bus_addr_hold", 64'(bus_addr), 64'(cur.a));
                checkOutput("bus_wdata_hold", 64'(bus_wdata), 64'(cur.d));
            end
            prev_req = bus_req;
            if (rdata_valid) begin
                if (resp_q.size() == 0) begin
                    checkOutput("unexpected_rdata_valid", 64'd1, 64'd0);
                end else begin
                    r = resp_q.pop_front();
                    checkOutput("resp_is_read", 64'(r.is_fault), 64'd0);
                    checkOutput("rdata", 64'(rdata), 64'(r.d));
                end
            end
            if (fault) begin
                if (resp_q.size() == 0) begin
                    checkOutput("unexpected_fault", 64'd1, 64'd0);
                end else begin
                    r = resp_q.pop_front();
                    checkOutput("resp_is_fault", 64'(r.is_fault), 64'd1);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic          rd, wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            wt;
        int            k;
        rst_n     = 1'b0;
        mem_read  = 1'b1;
        mem_write = 1'b0;
        addr      = 32'h100;
        wdata     = '0;
        force_ack = 1'b0;
        last_rd   = '0;
        ref_mem[32'h100] = 32'hDEADBEEF;
        bus_mem[32'h100] = 32'hDEADBEEF;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_stall", 64'(stall), 64'd0);
        checkOutput("reset_bus_req", 64'(bus_req), 64'd0);
        checkOutput("reset_bus_we", 64'(bus_we), 64'd0);
        checkOutput("reset_bus_addr", 64'(bus_addr), 64'd0);
        checkOutput("reset_bus_wdata", 64'(bus_wdata), 64'd0);
        checkOutput("reset_rdata", 64'(rdata), 64'd0);
        checkOutput("reset_rdata_valid", 64'(rdata_valid), 64'd0);
        checkOutput("reset_fault", 64'(fault), 64'd0);
        mem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 0);
        applyStimulus(1'b0, 1'b1, 32'h204, 32'h12345678, 3);
        applyStimulus(1'b1, 1'b1, 32'h208, 32'hCAFEF00D, 1);
        applyStimulus(1'b1, 1'b0, 32'h204, 32'h0, 0);
        applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 2);
        applyStimulus(1'b1, 1'b0, 32'h102, 32'h0, 0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 0);
        resetMidReq();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 0);

        for (int i = 0; i < 200; i++) begin
            k  = $urandom_range(0, 9);
            rd = (k >= 2 && k <= 5) || k == 9;
            wr = (k >= 6);
            a  = 32'h200 + 32'($urandom_range(0, 15)) * 4;
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            d  = $urandom;
            wt = $urandom_range(0, 4);
            applyStimulus(rd, wr, a, d, wt);
        end

        repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 0);
        repeat (2) @(negedge clk);
        checkOutput("bus_q_drained", 64'(bus_q.size()), 64'd0);
        checkOutput("resp_q_drained", 64'(resp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
